// File: rtl/demux_1_2_reg_pkg.sv
// Shared types and constants for the registered 1-to-2 demux.
// Slot occupancy encoding and delivered-word counter width.
package demux_1_2_reg_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_e;

  localparam int CNT_W = 16;

endpackage

// File: rtl/demux_out_slot.sv
// One-entry output slot of the demux: data register, occupancy
// state and a wrapping count of words delivered downstream.
module demux_out_slot
  import demux_1_2_reg_pkg::*;
#(
  parameter int BUS_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic [BUS_WIDTH-1:0] load_data_i,
  input  logic                 ready_i,
  output logic                 valid_o,
  output logic [BUS_WIDTH-1:0] data_o,
  output logic [CNT_W-1:0]     cnt_o,
  output logic                 free_o
);

  slot_state_e          state_q, state_d;
  logic [BUS_WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 drain;

  assign drain   = (state_q == FULL) && ready_i;
  assign valid_o = (state_q == FULL);
  assign data_o  = data_q;
  assign cnt_o   = cnt_q;
  assign free_o  = (state_q == EMPTY) || ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  // A load in the same cycle as a drain keeps the slot FULL.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      state_d = FULL;
      data_d  = load_data_i;
    end else if (drain) begin
      state_d = EMPTY;
    end
    if (drain) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/demux_1_2_reg.sv
// Registered 1-to-2 demux: steers each accepted word into the
// one-entry slot picked by sel, with per-output delivery counts.
module demux_1_2_reg
  import demux_1_2_reg_pkg::*;
#(
  parameter int BUS_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 sel,
  input  logic [BUS_WIDTH-1:0] in_data,
  output logic                 out0_valid,
  input  logic                 out0_ready,
  output logic [BUS_WIDTH-1:0] out0_data,
  output logic                 out1_valid,
  input  logic                 out1_ready,
  output logic [BUS_WIDTH-1:0] out1_data,
  output logic [CNT_W-1:0]     cnt0,
  output logic [CNT_W-1:0]     cnt1
);

  logic free0, free1;
  logic in_hs;
  logic load0, load1;

  assign in_ready = sel ? free1 : free0;
  assign in_hs    = in_valid && in_ready;
  assign load0    = in_hs && !sel;
  assign load1    = in_hs && sel;

  demux_out_slot #(
    .BUS_WIDTH(BUS_WIDTH)
  ) u_slot0 (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load0),
    .load_data_i(in_data),
    .ready_i    (out0_ready),
    .valid_o    (out0_valid),
    .data_o     (out0_data),
    .cnt_o      (cnt0),
    .free_o     (free0)
  );

  demux_out_slot #(
    .BUS_WIDTH(BUS_WIDTH)
  ) u_slot1 (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load1),
    .load_data_i(in_data),
    .ready_i    (out1_ready),
    .valid_o    (out1_valid),
    .data_o     (out1_data),
    .cnt_o      (cnt1),
    .free_o     (free1)
  );

endmodule

// File: tb/tb_demux_1_2_reg.sv
// Scoreboard bench for demux_1_2_reg: directed scenarios, random
// traffic and a full counter wrap against a queue-based model.
module tb_demux_1_2_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        sel;
  logic [15:0] in_data;
  logic        out0_valid, out0_ready;
  logic [15:0] out0_data;
  logic        out1_valid, out1_ready;
  logic [15:0] out1_data;
  logic [15:0] cnt0, cnt1;

  demux_1_2_reg #(.BUS_WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .in_data   (in_data),
    .out0_valid(out0_valid),
    .out0_ready(out0_ready),
    .out0_data (out0_data),
    .out1_valid(out1_valid),
    .out1_ready(out1_ready),
    .out1_data (out1_data),
    .cnt0      (cnt0),
    .cnt1      (cnt1)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  bit          started = 0;
  logic [15:0] sb0[$];
  logic [15:0] sb1[$];
  logic [15:0] last0, last1;
  logic [15:0] mcnt0, mcnt1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: slot contents and counters versus the model; pops on drain.
  always @(negedge clk) begin
    if (started && !rst) begin
      logic [15:0] e;
      chk("out0_valid", out0_valid, sb0.size() != 0);
      chk("out1_valid", out1_valid, sb1.size() != 0);
      chk("out0_data", out0_data, last0);
      chk("out1_data", out1_data, last1);
      chk("cnt0", cnt0, mcnt0);
      chk("cnt1", cnt1, mcnt1);
      if (out0_valid && out0_ready) begin
        if (sb0.size() == 0) begin
          chk("pop0_empty", 1, 0);
        end else begin
          e = sb0.pop_front();
          chk("deliver0", out0_data, e);
          mcnt0 = mcnt0 + 16'd1;
        end
      end
      if (out1_valid && out1_ready) begin
        if (sb1.size() == 0) begin
          chk("pop1_empty", 1, 0);
        end else begin
          e = sb1.pop_front();
          chk("deliver1", out1_data, e);
          mcnt1 = mcnt1 + 16'd1;
        end
      end
    end
  end

  task automatic clear_model();
    sb0.delete();
    sb1.delete();
    last0 = '0;
    last1 = '0;
    mcnt0 = '0;
    mcnt1 = '0;
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic do_reset(logic v, logic r0, logic r1);
    rst = 1'b1;
    in_valid = v;
    out0_ready = r0;
    out1_ready = r1;
    @(posedge clk);
    #1;
    clear_model();
    rst = 1'b0;
  endtask

  task automatic cyc(logic v, logic s, logic [15:0] d,
                     logic r0, logic r1);
    logic free, acc;
    in_valid = v;
    sel = s;
    in_data = d;
    out0_ready = r0;
    out1_ready = r1;
    free = s ? (sb1.size() == 0 || r1) : (sb0.size() == 0 || r0);
    acc = v && free;
    #1;
    chk("in_ready", in_ready, free);
    @(posedge clk);
    #1;
    if (acc) begin
      if (s) begin
        sb1.push_back(d);
        last1 = d;
      end else begin
        sb0.push_back(d);
        last0 = d;
      end
    end
  endtask

  initial begin
    logic [15:0] c0;
    rst = 1'b1;
    in_valid = 1'b0;
    sel = 1'b0;
    in_data = '0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    clear_model();
    @(posedge clk);
    #1;
    do_reset(0, 0, 0);
    started = 1;
    chk("rst_valid0", out0_valid, 0);
    chk("rst_cnt1", cnt1, 0);

    // basic routing
    cyc(1, 0, 16'h5, 1, 1);
    chk("route0", out0_data, 16'h5);
    cyc(1, 1, 16'hA, 1, 1);
    chk("route1", out1_data, 16'hA);
    cyc(0, 0, 16'h0, 1, 1);
    chk("route_cnt0", cnt0, 1);
    chk("route_cnt1", cnt1, 1);

    // backpressure on slot 0, slot 1 still accepts
    cyc(1, 0, 16'h3, 0, 1);
    cyc(1, 0, 16'hC, 0, 1);
    chk("bp_hold0", out0_data, 16'h3);
    cyc(1, 1, 16'hC, 0, 1);
    chk("bp_route1", out1_data, 16'hC);
    chk("bp_still0", out0_data, 16'h3);

    // simultaneous drain and fill
    c0 = cnt0;
    cyc(1, 0, 16'h7, 1, 0);
    chk("df_valid", out0_valid, 1);
    chk("df_data", out0_data, 16'h7);
    chk("df_cnt", cnt0, c0 + 16'd1);

    // sel glitching with no valid: nothing moves
    for (int i = 0; i < 6; i++) begin
      cyc(0, i[0], 16'hFFFF, 0, 0);
    end
    chk("gl_data0", out0_data, 16'h7);
    chk("gl_data1", out1_data, 16'hC);
    chk("gl_cnt0", cnt0, c0 + 16'd1);

    // reset with both slots full and consumers ready
    chk("pre_rst_v0", out0_valid, 1);
    chk("pre_rst_v1", out1_valid, 1);
    do_reset(1, 1, 1);
    in_valid = 1'b0;
    chk("mr_valid0", out0_valid, 0);
    chk("mr_valid1", out1_valid, 0);
    chk("mr_data0", out0_data, 0);
    chk("mr_data1", out1_data, 0);
    chk("mr_cnt0", cnt0, 0);
    chk("mr_cnt1", cnt1, 0);
    #1;
    chk("mr_in_ready", in_ready, 1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
          16'($urandom), $urandom_range(0, 2) != 0,
          $urandom_range(0, 2) != 0);
    end

    // counter wrap on output 1
    do_reset(0, 0, 0);
    for (int i = 1; i <= 65537; i++) begin
      cyc(1, 1, 16'($urandom), 0, 1);
      if (i == 65536) chk("wrap_ffff", cnt1, 16'hFFFF);
      if (i == 65537) chk("wrap_0000", cnt1, 16'h0000);
    end
    cyc(0, 1, 16'h0, 0, 1);
    chk("wrap_0001", cnt1, 16'h0001);
    chk("wrap_empty", out1_valid, 0);

    cyc(0, 0, 16'h0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_1_2_reg.md
DEMUX_1_2_REG -- requirements
Module: demux_1_2_reg

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 16, giving the data width of the input and both outputs.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, with synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1, meaning the producer offers in_data/sel.
REQ-005 SHALL have port in_ready, output, 1, meaning the block accepts this cycle.
REQ-006 SHALL have port sel, input, 1, the destination: 0 selects out0, 1 selects out1.
REQ-007 SHALL have port in_data, input, BUS_WIDTH, the payload.
REQ-008 SHALL have ports out0_valid/out1_valid, output, 1, meaning the slot holds a word.
REQ-009 SHALL have ports out0_ready/out1_ready, input, 1, meaning the consumer takes the word.
REQ-010 SHALL have ports out0_data/out1_data, output, BUS_WIDTH, the slot contents.
REQ-011 SHALL have ports cnt0/cnt1, output, 16, giving delivered-word counts per output.

Function
REQ-012 SHALL take an input handshake as in_valid && in_ready on a rising edge of clk.
REQ-013 SHALL take an output-K handshake as outK_valid && outK_ready on a rising edge of clk.
REQ-014 SHALL give each output a one-entry slot with states EMPTY (outK_valid=0) and FULL (outK_valid=1).
REQ-015 SHALL move a slot EMPTY->FULL on an input handshake with sel=K.
REQ-016 SHALL move a slot FULL->EMPTY on an output handshake with no input handshake to K in the same cycle.
REQ-017 SHALL keep a slot FULL, loaded with the new in_data, when an output handshake and an input handshake to K coincide.
REQ-018 SHALL drive in_ready combinationally = (sel==0 ? (!out0_valid || out0_ready) : (!out1_valid || out1_ready)).
REQ-019 SHALL sample sel only on an input handshake; sel changes while in_valid is low or blocked have no effect.
REQ-020 SHALL have a latency of exactly 1 cycle: a word accepted at edge N appears on outK_data with outK_valid=1 after edge N.
REQ-021 SHALL hold outK_data stable while outK_valid=1 and outK_ready=0, and keep its last value when EMPTY.
REQ-022 SHALL leave the non-selected slot untouched by an input handshake; it may drain in the same cycle.
REQ-023 SHALL block the input when the selected slot is FULL and not draining, with no effect on the other slot.
REQ-024 SHALL increment cntK by 1 on each output-K handshake, wrapping modulo 2^16 (16'hFFFF -> 16'h0000).
REQ-025 SHALL never drop or duplicate a word; per-output order equals acceptance order.

Reset
REQ-026 SHALL, while rst=1 at a clock edge, clear out0_valid, out1_valid, out0_data, out1_data, cnt0 and cnt1 to 0.
REQ-027 SHALL discard any word held in a slot when reset arrives mid-operation, counting no handshake that cycle.
REQ-028 SHALL drive in_ready, while in reset, by REQ-018 from the cleared slots, with no handshake taking effect.

Structure
REQ-029 SHALL place in a shared package the slot state encoding (EMPTY=0, FULL=1) and the counter width constant CNT_W=16.
REQ-030 SHALL instantiate one sub-module, demux_out_slot (slot register, valid flag, counter), twice, once per output.

Verification
REQ-031 SHALL verify basic routing: after reset, out ready=1, send 16'h5 with sel=0, then 16'hA with sel=1 -> out0_data=16'h5 one cycle after the first, out1_data=16'hA one cycle after the second; cnt0=1, cnt1=1.
REQ-032 SHALL verify backpressure: out0_ready=0, send 16'h3 sel=0, then offer 16'hC sel=0 -> in_ready=0 and out0_data stays 16'h3; offer 16'hC sel=1 -> accepted and out1_data=16'hC.
REQ-033 SHALL verify simultaneous drain and fill: slot0 FULL with 16'h3, out0_ready=1, in_valid=1 sel=0 with 16'h7 -> out0_valid stays 1 and out0_data=16'h7 next cycle; cnt0 increments by 1.
REQ-034 SHALL verify counter wrap: drive 65537 output-1 handshakes -> cnt1 passes 16'hFFFF, then reads 16'h0000, then 16'h0001.
REQ-035 SHALL verify reset mid-operation: both slots FULL, assert rst for one cycle -> out0_valid=out1_valid=0, data=0, cnt0=cnt1=0, in_ready=1.
REQ-036 SHALL verify sel glitching: toggle sel every cycle with in_valid=0 -> no slot or counter change.
